// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic feeder and the systolic array:
//   - default element width and matrix geometry
//   - feeder state encoding
//   - element, row and lane vector typedefs at the default geometry
//   - clog2_min1: counter width helper that never returns zero
// ---------------------------------------------------------------------------
package systolic_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_ROWS  = 10;
   localparam int DEF_COLS  = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FULL = 2'd1,
      ST_FEED = 2'd2,
      ST_DONE = 2'd3
   } feeder_state_t;

   typedef logic signed [DEF_WIDTH-1:0] elem_t;
   typedef elem_t [DEF_COLS-1:0]        row_t;
   typedef elem_t [DEF_ROWS-1:0]        lane_vec_t;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/systolic_feeder_lane.sv
// ---------------------------------------------------------------------------
// systolic_feeder_lane
// Index window and element select for one west-edge lane. At beat t the
// lane is valid when 0 <= t-LANE < N and then presents src[t-LANE];
// otherwise it outputs zero.
// Ports:
//   t      in   beat index
//   src    in   N elements this lane draws from (a matrix row or column)
//   valid  out  lane element valid at beat t
//   data   out  selected element, zero when not valid
// ---------------------------------------------------------------------------
module systolic_feeder_lane
   import systolic_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int N     = DEF_COLS,
   parameter int LANE  = 0,
   parameter int TW    = 5
) (
   input  logic [TW-1:0]            t,
   input  logic [N-1:0][WIDTH-1:0]  src,
   output logic                     valid,
   output logic [WIDTH-1:0]         data
);

   localparam logic [TW-1:0] LANE_T = TW'(LANE);
   localparam logic [TW-1:0] N_T    = TW'(N);

   logic [TW-1:0] idx;

   always_comb begin
      idx   = t - LANE_T;
      valid = 1'b0;
      data  = '0;
      // t >= LANE guards against idx wrapping to a large value
      if (t >= LANE_T && idx < N_T) begin
         valid = 1'b1;
         for (int k = 0; k < N; k++) begin
            if (idx == TW'(k)) data = src[k];
         end
      end
   end

endmodule

// File: rtl/systolic_feeder.sv
// ---------------------------------------------------------------------------
// systolic_feeder
// Buffers a ROWS x COLS matrix one row per write beat, then feeds it as a
// skewed wavefront into the west edge of a systolic array: lane i carries
// row i delayed by i beats. The feed lasts ROWS+COLS-1 beats and advances
// only when out_ready is high.
// Build option: define SYSTOLIC_FEEDER_TRANSPOSE_EN to feed column i on
// lane i instead (requires ROWS == COLS).
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   wr_valid    row write strobe (accepted while wr_ready)
//   wr_ready    high in IDLE
//   wr_data     one matrix row, element k is column k
//   start       begin the feed (honoured only with a full buffer)
//   out_ready   array accepts the current beat
//   out_valid   per-lane element valid
//   out_data    per-lane element
//   busy        high while feeding
//   done        one-cycle pulse after the last beat is accepted
// ---------------------------------------------------------------------------
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ROWS  = DEF_ROWS,
   parameter int COLS  = DEF_COLS
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_valid,
   output logic                         wr_ready,
   input  logic [COLS-1:0][WIDTH-1:0]   wr_data,
   input  logic                         start,
   input  logic                         out_ready,
   output logic [ROWS-1:0]              out_valid,
   output logic [ROWS-1:0][WIDTH-1:0]   out_data,
   output logic                         busy,
   output logic                         done
);

   localparam int BEATS = ROWS + COLS - 1;
   localparam int TW    = clog2_min1(BEATS);
   localparam int RW    = clog2_min1(ROWS);
   localparam logic [TW-1:0] LAST_T   = TW'(BEATS - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

   feeder_state_t state_q, state_d;
   logic [RW-1:0] row_cnt_q, row_cnt_d;
   logic [TW-1:0] t_q, t_d;

   logic [COLS-1:0][WIDTH-1:0] buf_q [ROWS];

   logic [ROWS-1:0]            lane_valid;
   logic [ROWS-1:0][WIDTH-1:0] lane_data;

`ifdef SYSTOLIC_FEEDER_TRANSPOSE_EN
   if (ROWS != COLS) begin : g_bad_geometry
      $error("systolic_feeder: transpose feed needs ROWS == COLS");
   end
`endif

   // Lanes look at the next beat index so the output registers already hold
   // beat 0 in the first FEED cycle.
   for (genvar i = 0; i < ROWS; i++) begin : g_lane
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_EN
      logic [ROWS-1:0][WIDTH-1:0] src;
      always_comb begin
         for (int j = 0; j < ROWS; j++) src[j] = buf_q[j][i];
      end
      localparam int N = ROWS;
`else
      logic [COLS-1:0][WIDTH-1:0] src;
      assign src = buf_q[i];
      localparam int N = COLS;
`endif
      systolic_feeder_lane #(
         .WIDTH (WIDTH),
         .N     (N),
         .LANE  (i),
         .TW    (TW)
      ) u_lane (
         .t     (t_d),
         .src   (src),
         .valid (lane_valid[i]),
         .data  (lane_data[i])
      );
   end

   always_comb begin
      state_d   = state_q;
      row_cnt_d = row_cnt_q;
      t_d       = t_q;
      case (state_q)
         ST_IDLE: begin
            if (wr_valid) begin
               row_cnt_d = row_cnt_q + 1'b1;
               if (row_cnt_q == LAST_ROW) begin
                  state_d   = ST_FULL;
                  row_cnt_d = '0;
               end
            end
         end
         ST_FULL: begin
            if (start) begin
               state_d = ST_FEED;
               t_d     = '0;
            end
         end
         ST_FEED: begin
            if (out_ready) begin
               if (t_q == LAST_T) begin
                  state_d = ST_DONE;
                  t_d     = '0;
               end else begin
                  t_d = t_q + 1'b1;
               end
            end
         end
         default: begin
            state_d   = ST_IDLE;
            row_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         row_cnt_q <= '0;
         t_q       <= '0;
         for (int r = 0; r < ROWS; r++) buf_q[r] <= '0;
         wr_ready  <= 1'b1;
         out_valid <= '0;
         out_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_cnt_q <= row_cnt_d;
         t_q       <= t_d;
         if (state_q == ST_IDLE && wr_valid) buf_q[row_cnt_q] <= wr_data;
         wr_ready  <= (state_d == ST_IDLE);
         busy      <= (state_d == ST_FEED);
         done      <= (state_d == ST_DONE);
         if (state_d == ST_FEED) begin
            out_valid <= lane_valid;
            out_data  <= lane_data;
         end else begin
            out_valid <= '0;
            out_data  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;

   localparam int W = 16;
   localparam int R = 10;
   localparam int C = 10;

   logic                   clk;
   logic                   rst;
   logic                   wr_valid;
   logic                   wr_ready;
   logic [C-1:0][W-1:0]    wr_data;
   logic                   start;
   logic                   out_ready;
   logic [R-1:0]           out_valid;
   logic [R-1:0][W-1:0]    out_data;
   logic                   busy;
   logic                   done;

   logic [W-1:0] mat [R][C];
   int n_tests = 0;
   int n_fail  = 0;
   int spot_mode = 0;

   systolic_feeder #(.WIDTH(W), .ROWS(R), .COLS(C)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_data   (wr_data),
      .start     (start),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic exp_valid(input int t, input int i);
      return (t - i >= 0) && (t - i < C);
   endfunction

   function automatic logic [W-1:0] exp_data(input int t, input int i);
      int k;
      k = t - i;
      if (k < 0 || k >= C) return '0;
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_EN
      return mat[k][i];
`else
      return mat[i][k];
`endif
   endfunction

   task automatic check_beat(input int t);
      for (int i = 0; i < R; i++) begin
         chk($sformatf("b%0d_valid%0d", t, i), 32'(out_valid[i]), 32'(exp_valid(t, i)));
         chk($sformatf("b%0d_data%0d", t, i), 32'(out_data[i]), 32'(exp_data(t, i)));
      end
      if (spot_mode == 1) begin
         if (t == 0) begin
            chk("b0_lane0_literal", 32'(out_data[0]), 32'd123);
            chk("b0_valid_vec", 32'(out_valid), 32'h001);
         end
         if (t == 1) begin
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_EN
            chk("b1_lane0_literal", 32'(out_data[0]), 32'd76);
            chk("b1_lane1_literal", 32'(out_data[1]), 32'd45);
`else
            chk("b1_lane0_literal", 32'(out_data[0]), 32'd45);
            chk("b1_lane1_literal", 32'(out_data[1]), 32'd76);
`endif
         end
         if (t == 18) begin
            chk("b18_valid_vec", 32'(out_valid), 32'h200);
            chk("b18_lane9_literal", 32'(out_data[9]), 32'd12);
         end
      end
      if (spot_mode == 2) begin
         if (t == 0) chk("neg_b0_lane0", 32'(out_data[0]), 32'h0000ffff);
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_EN
         if (t == 1) chk("neg_b1_lane1", 32'(out_data[1]), 32'h00008000);
`else
         if (t == 1) chk("neg_b1_lane0", 32'(out_data[0]), 32'h00008000);
`endif
      end
   endtask

   task automatic load_rows(input int first, input int last);
      for (int r = first; r <= last; r++) begin
         wr_valid = 1'b1;
         for (int c = 0; c < C; c++) wr_data[c] = mat[r][c];
         tick();
      end
      wr_valid = 1'b0;
   endtask

   task automatic run_feed(input int stall_beat, output int beats, output int dones);
      int  t;
      int  stalls;
      logic rdy;
      t = 0; stalls = 0; beats = 0; dones = 0;
      out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (done) dones++;
         if (busy) begin
            check_beat(t);
            rdy = !(t == stall_beat && stalls < 3);
            if (!rdy) stalls++;
            out_ready = rdy;
            tick();
            if (rdy) begin
               t++;
               beats++;
            end
            out_ready = 1'b1;
         end else begin
            tick();
         end
      end
   endtask

   initial begin
      int row0[10];
      int beats;
      int dones;
      row0 = '{123, 45, 89, 200, 34, 67, 155, 210, 11, 98};
      for (int i = 0; i < R; i++)
         for (int j = 0; j < C; j++)
            mat[i][j] = W'((i * 37 + j * 53 + 7) % 256);
      for (int j = 0; j < C; j++) mat[0][j] = W'(row0[j]);
      mat[1][0] = 16'd76;
      mat[1][1] = 16'd233;
      mat[9][9] = 16'd12;

      rst = 1'b1; wr_valid = 1'b0; wr_data = '0; start = 1'b0; out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_wr_ready", 32'(wr_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data0", 32'(out_data[0]), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      tick();

      // full load, uninterrupted feed
      load_rows(0, 9);
      chk("full_wr_ready", 32'(wr_ready), 32'd0);
      spot_mode = 1;
      run_feed(-1, beats, dones);
      chk("feed1_beats", 32'(beats), 32'd19);
      chk("feed1_dones", 32'(dones), 32'd1);
      chk("feed1_idle_wr_ready", 32'(wr_ready), 32'd1);
      chk("feed1_idle_valid", 32'(out_valid), 32'd0);

      // stalled feed: frozen at beat 5 for three cycles
      spot_mode = 0;
      load_rows(0, 9);
      run_feed(5, beats, dones);
      chk("feed2_beats", 32'(beats), 32'd19);
      chk("feed2_dones", 32'(dones), 32'd1);

      // partial load ignores start
      load_rows(0, 5);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("partial_busy", 32'(busy), 32'd0);
      chk("partial_valid", 32'(out_valid), 32'd0);
      chk("partial_wr_ready", 32'(wr_ready), 32'd1);
      tick();
      chk("partial_busy2", 32'(busy), 32'd0);
      load_rows(6, 9);
      chk("partial_full_wr_ready", 32'(wr_ready), 32'd0);
      chk("partial_full_busy", 32'(busy), 32'd0);

      // reset at beat 8
      out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (8) tick();
      chk("pre_abort_busy", 32'(busy), 32'd1);
      check_beat(8);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_wr_ready", 32'(wr_ready), 32'd1);
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      for (int k = 0; k < 5; k++) begin
         chk("abort_no_done", 32'(done), 32'd0);
         tick();
      end

      // negative values pass bit-exact
      mat[0][0] = 16'hFFFF;
      mat[0][1] = 16'h8000;
      mat[5][5] = 16'h8000;
      mat[9][0] = 16'hFFFF;
      load_rows(0, 9);
      spot_mode = 2;
      run_feed(-1, beats, dones);
      chk("feed3_beats", 32'(beats), 32'd19);
      chk("feed3_dones", 32'(dones), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
